// File: rtl/abcd_pkg.sv
// Shared types and defaults for the a/b/c/d responder.
package abcd_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned DATA_MAX_DEF = 200;

  typedef enum logic [1:0] {
    EN_BOTH = 2'd0,
    EN_1    = 2'd1,
    EN_2    = 2'd2
  } en_state_t;

  // Rotation order EN_BOTH -> EN_1 -> EN_2 -> EN_BOTH; stray codes recover to EN_BOTH.
  function automatic en_state_t en_next(en_state_t s);
    case (s)
      EN_BOTH: en_next = EN_1;
      EN_1:    en_next = EN_2;
      default: en_next = EN_BOTH;
    endcase
  endfunction

  // Returns {enable_1, enable_2}; every code, including the unused one, keeps a lane on.
  function automatic logic [1:0] en_decode(en_state_t s);
    case (s)
      EN_1:    en_decode = 2'b10;
      EN_2:    en_decode = 2'b01;
      default: en_decode = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator: clear wins over accumulate, result clamps at DATA_MAX.
module sat_accum
  import abcd_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DATA_MAX = DATA_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              valid,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam logic [DATA_W:0]   MAX_EXT = (DATA_W + 1)'(DATA_MAX);
  localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(DATA_MAX);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W:0]   sum;

  // One extra bit of headroom so the carry out of the add is visible to the clamp.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, din};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (valid) begin
      acc_d = (sum > MAX_EXT) ? MAX_VAL : sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign dout = acc_q;

endmodule

// File: rtl/abcd_responder.sv
// Responder side of the a/b/c/d handshake: enable rotation, c/d generation,
// saturating data word and a sticky flag for initiator a&&c -> ##2 b violations.
module abcd_responder
  import abcd_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DATA_MAX = DATA_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a,
  input  logic              b,
  input  logic              req_swap,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_clr,
  output logic              c,
  output logic              d,
  output logic              enable_1,
  output logic              enable_2,
  output logic [DATA_W-1:0] data,
  output logic              proto_err
);

  en_state_t state_q, state_d;
  logic      en1_q, en1_d;
  logic      en2_q, en2_d;

  logic a_prev_q, a_prev_d;
  logic c_q, c_d;
  logic d_q, d_d;
  logic sus_q, sus_d;
  logic seq1_q, seq1_d;
  logic seq2_q, seq2_d;
  logic pe1_q, pe1_d;
  logic pe2_q, pe2_d;
  logic err_q, err_d;

  // Enables are decoded from the next state so they land in the same cycle as the state.
  always_comb begin
    state_d = state_q;
    if (req_swap) begin
      state_d = en_next(state_q);
    end
    {en1_d, en2_d} = en_decode(state_d);
  end

  // c/d pipelines and the violation checker; sustain and sequence terms run independently.
  always_comb begin
    a_prev_d = a;
    c_d      = (a & ~b) | (a_prev_q & b);
    sus_d    = b & c_q & d_q;
    seq1_d   = a;
    seq2_d   = seq1_q & c_q;
    d_d      = sus_q | (seq2_q & b);
    pe1_d    = a & c_q;
    pe2_d    = pe1_q;
    err_d    = err_q | (pe2_q & ~b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EN_BOTH;
      en1_q    <= 1'b1;
      en2_q    <= 1'b1;
      a_prev_q <= 1'b0;
      c_q      <= 1'b0;
      d_q      <= 1'b0;
      sus_q    <= 1'b0;
      seq1_q   <= 1'b0;
      seq2_q   <= 1'b0;
      pe1_q    <= 1'b0;
      pe2_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en1_q    <= en1_d;
      en2_q    <= en2_d;
      a_prev_q <= a_prev_d;
      c_q      <= c_d;
      d_q      <= d_d;
      sus_q    <= sus_d;
      seq1_q   <= seq1_d;
      seq2_q   <= seq2_d;
      pe1_q    <= pe1_d;
      pe2_q    <= pe2_d;
      err_q    <= err_d;
    end
  end

  sat_accum #(
    .DATA_W   (DATA_W),
    .DATA_MAX (DATA_MAX)
  ) u_sat_accum (
    .clk   (clk),
    .reset (reset),
    .clr   (data_clr),
    .valid (data_valid),
    .din   (data_in),
    .dout  (data)
  );

  assign c         = c_q;
  assign d         = d_q;
  assign enable_1  = en1_q;
  assign enable_2  = en2_q;
  assign proto_err = err_q;

endmodule
